// File: rtl/game_pkg.sv
// Shared types and key codes for the parametrised 24-game engine.
// Key decode: 1..N select a slot, A..D pick an operator, E undoes, F clears.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL0,
        ST_SEL1,
        ST_SEL2,
        ST_EXEC,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    localparam logic [3:0] KEY_OP_BASE = 4'hA;
    localparam logic [3:0] KEY_OP_LAST = 4'hD;
    localparam logic [3:0] KEY_UNDO    = 4'hE;
    localparam logic [3:0] KEY_CLR     = 4'hF;

endpackage

// File: rtl/game_alu.sv
// Combinational W-bit move evaluator for the game engine.
// Flags results that cannot be shown as an exact unsigned W-bit value.
module game_alu
    import game_pkg::*;
#(
    parameter int W = 10
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  op_t          op,
    output logic [W-1:0] r,
    output logic         reject
);

    logic [W:0]     sum;
    logic [2*W-1:0] prod;
    logic [W-1:0]   dvs;
    logic [W-1:0]   quo;
    logic [W-1:0]   rem;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    // A zero divisor is rejected anyway; divide by one to keep the divider defined.
    assign dvs  = (b == '0) ? W'(1) : b;
    assign quo  = a / dvs;
    assign rem  = a % dvs;

    always_comb begin
        r      = '0;
        reject = 1'b0;
        unique case (op)
            OP_ADD: begin
                r      = sum[W-1:0];
                reject = sum[W];
            end
            OP_SUB: begin
                r      = a - b;
                reject = (a < b);
            end
            OP_MUL: begin
                r      = prod[W-1:0];
                reject = |prod[2*W-1:W];
            end
            OP_DIV: begin
                r      = quo;
                reject = (b == '0) || (rem != '0);
            end
            default: begin
                r      = '0;
                reject = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/game_engine_n.sv
// N-value arithmetic game controller: select two slots and an operator per move.
// Define UNDO_EN to add an (N_NUMS-1)-deep move history popped by key E.
module game_engine_n
    import game_pkg::*;
#(
    parameter int N_NUMS = 4,
    parameter int W      = 10,
    parameter int TARGET = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                restart,
    input  logic [N_NUMS*W-1:0] seed_nums,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    output logic [N_NUMS*W-1:0] nums,
    output logic [N_NUMS-1:0]   valid_mask,
    output logic                win,
    output logic                lose,
    output logic                err
);

    localparam int NW = N_NUMS * W;
    localparam int IW = $clog2(N_NUMS);
    localparam logic [3:0] MAX_KEY = 4'(N_NUMS);

    state_t            state_q, state_d;
    logic [NW-1:0]     nums_q, nums_d;
    logic [NW-1:0]     seed_q, seed_d;
    logic [N_NUMS-1:0] mask_q, mask_d;
    logic [IW-1:0]     a_q, a_d;
    logic [IW-1:0]     b_q, b_d;
    op_t               op_q, op_d;
    logic              opv_q, opv_d;
    logic              win_q, win_d;
    logic              lose_q, lose_d;
    logic              err_q, err_d;

    logic [IW-1:0] slot, lo, hi;
    logic          is_slot, slot_ok, is_op;
    logic [W-1:0]  opa, opb, alu_r, last_val;
    logic          alu_rej;
    logic          load;
    logic [NW-1:0] load_val;

`ifdef UNDO_EN
    localparam int DEPTH = N_NUMS - 1;
    typedef logic [NW+N_NUMS-1:0] snap_t;
    snap_t         stk_q [DEPTH];
    snap_t         stk_d [DEPTH];
    logic [IW-1:0] sp_q, sp_d;
    logic [IW-1:0] top_idx;
    logic          undo_req;
    assign top_idx = sp_q - 1'b1;
`endif

    assign slot    = IW'(key_code - 4'd1);
    assign is_slot = (key_code != 4'd0) && (key_code <= MAX_KEY);
    assign slot_ok = is_slot && mask_q[slot];
    assign is_op   = (key_code >= KEY_OP_BASE) && (key_code <= KEY_OP_LAST);
    assign opa     = nums_q[a_q*W +: W];
    assign opb     = nums_q[b_q*W +: W];
    assign lo      = (a_q < b_q) ? a_q : b_q;
    assign hi      = (a_q < b_q) ? b_q : a_q;
    assign load    = start | restart;
    assign load_val = start ? seed_nums : seed_q;

    game_alu #(.W(W)) u_alu (
        .a      (opa),
        .b      (opb),
        .op     (op_q),
        .r      (alu_r),
        .reject (alu_rej)
    );

    always_comb begin
        state_d  = state_q;
        nums_d   = nums_q;
        seed_d   = seed_q;
        mask_d   = mask_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        opv_d    = opv_q;
        win_d    = win_q;
        lose_d   = lose_q;
        err_d    = 1'b0;
        last_val = '0;
`ifdef UNDO_EN
        stk_d    = stk_q;
        sp_d     = sp_q;
        undo_req = 1'b0;
`endif
        for (int i = 0; i < N_NUMS; i++) begin
            if (mask_q[i]) last_val = last_val | nums_q[i*W +: W];
        end

        if (load) begin
            nums_d  = load_val;
            mask_d  = '1;
            if (start) seed_d = seed_nums;
            win_d   = 1'b0;
            lose_d  = 1'b0;
            a_d     = '0;
            b_d     = '0;
            op_d    = OP_ADD;
            opv_d   = 1'b0;
            state_d = ST_SEL0;
`ifdef UNDO_EN
            sp_d    = '0;
`endif
        end else begin
            case (state_q)
                ST_EXEC: begin
                    if (alu_rej) begin
                        err_d = 1'b1;
                    end else begin
                        nums_d[lo*W +: W] = alu_r;
                        mask_d[hi]        = 1'b0;
`ifdef UNDO_EN
                        if (sp_q != IW'(DEPTH)) begin
                            stk_d[sp_q] = {nums_q, mask_q};
                            sp_d        = sp_q + 1'b1;
                        end
`endif
                    end
                    a_d     = '0;
                    b_d     = '0;
                    op_d    = OP_ADD;
                    opv_d   = 1'b0;
                    state_d = ST_SEL0;
                end
                ST_DONE: begin
`ifdef UNDO_EN
                    undo_req = key_valid && (key_code == KEY_UNDO);
`endif
                end
                ST_SEL0, ST_SEL1, ST_SEL2: begin
                    // Only a completed move can leave a single slot in play.
                    if (state_q == ST_SEL0 && $onehot(mask_q)) begin
                        win_d   = (last_val == W'(TARGET));
                        lose_d  = (last_val != W'(TARGET));
                        state_d = ST_DONE;
                    end else if (key_valid) begin
                        if (key_code == KEY_CLR) begin
                            a_d     = '0;
                            b_d     = '0;
                            op_d    = OP_ADD;
                            opv_d   = 1'b0;
                            state_d = ST_SEL0;
                        end else if (is_op) begin
                            op_d  = op_t'(2'(key_code - KEY_OP_BASE));
                            opv_d = 1'b1;
                        end else if (slot_ok) begin
                            if (state_q == ST_SEL0) begin
                                a_d     = slot;
                                state_d = ST_SEL1;
                            end else if (state_q == ST_SEL1 && slot != a_q) begin
                                b_d     = slot;
                                state_d = ST_SEL2;
                            end
                        end
`ifdef UNDO_EN
                        undo_req = (key_code == KEY_UNDO);
`endif
                        if (state_d == ST_SEL2 && opv_d) state_d = ST_EXEC;
                    end
                end
                default: ;
            endcase
        end

`ifdef UNDO_EN
        if (undo_req) begin
            if (sp_q == '0) begin
                err_d = 1'b1;
            end else begin
                {nums_d, mask_d} = stk_q[top_idx];
                sp_d    = top_idx;
                win_d   = 1'b0;
                lose_d  = 1'b0;
                a_d     = '0;
                b_d     = '0;
                op_d    = OP_ADD;
                opv_d   = 1'b0;
                state_d = ST_SEL0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            nums_q  <= '0;
            seed_q  <= '0;
            mask_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            opv_q   <= 1'b0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            nums_q  <= nums_d;
            seed_q  <= seed_d;
            mask_q  <= mask_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            opv_q   <= opv_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
            err_q   <= err_d;
        end
    end

`ifdef UNDO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
            for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
        end else begin
            sp_q  <= sp_d;
            stk_q <= stk_d;
        end
    end
`endif

    assign nums       = nums_q;
    assign valid_mask = mask_q;
    assign win        = win_q;
    assign lose       = lose_q;
    assign err        = err_q;

endmodule

// File: tb/tb_game_engine_n.sv
// Directed bench for game_engine_n with N_NUMS=4, W=10, TARGET=24.
module tb_game_engine_n;

    localparam int N = 4;
    localparam int W = 10;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           restart;
    logic [N*W-1:0] seed_nums;
    logic           key_valid;
    logic [3:0]     key_code;
    logic [N*W-1:0] nums;
    logic [N-1:0]   valid_mask;
    logic           win;
    logic           lose;
    logic           err;

    int tests   = 0;
    int fails   = 0;
    int err_cnt = 0;

    game_engine_n #(.N_NUMS(N), .W(W), .TARGET(24)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .restart    (restart),
        .seed_nums  (seed_nums),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .nums       (nums),
        .valid_mask (valid_mask),
        .win        (win),
        .lose       (lose),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (err === 1'b1) err_cnt++;

    function automatic logic [N*W-1:0] p4(int a, int b, int c, int d);
        return {W'(d), W'(c), W'(b), W'(a)};
    endfunction

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_start(input logic [N*W-1:0] s);
        @(negedge clk);
        seed_nums = s;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; restart = 1'b0;
        key_valid = 1'b0; key_code = 4'h0; seed_nums = '0;
        repeat (2) @(negedge clk);
        tests++;
        if (nums !== '0 || valid_mask !== '0) begin
            $display("FAIL reset_state nums=%h mask=%b want 0", nums, valid_mask);
            fails++;
        end
        tests++;
        if ({win, lose, err} !== 3'b000) begin
            $display("FAIL reset_flags got %b want 000", {win, lose, err});
            fails++;
        end
        rst_n = 1'b1;
        press(4'h1); press(4'h2); press(4'hA);
        tests++;
        if (nums !== '0 || valid_mask !== '0) begin
            $display("FAIL idle_keys nums=%h mask=%b want 0", nums, valid_mask);
            fails++;
        end
    endtask

    task automatic test_win();
        int e0;
        do_start(p4(4, 6, 1, 1));
        e0 = err_cnt;
        press(4'h1); press(4'h2); press(4'hC);
        tests++;
        if (nums !== p4(24, 6, 1, 1) || valid_mask !== 4'b1101) begin
            $display("FAIL win_mv1 nums=%h mask=%b want %h 1101", nums, valid_mask, p4(24, 6, 1, 1));
            fails++;
        end
        press(4'h3); press(4'h4); press(4'hC);
        press(4'h1); press(4'h3); press(4'hC);
        tests++;
        if (valid_mask !== 4'b0001 || nums[W-1:0] !== W'(24)) begin
            $display("FAIL win_final mask=%b n0=%0d want 0001 24", valid_mask, nums[W-1:0]);
            fails++;
        end
        tests++;
        if (win !== 1'b1 || lose !== 1'b0 || err_cnt !== e0) begin
            $display("FAIL win_flags win=%b lose=%b errs=%0d want 1 0 %0d", win, lose, err_cnt, e0);
            fails++;
        end
    endtask

    task automatic test_reject();
        int e0;
        do_start(p4(3, 5, 0, 2));
        e0 = err_cnt;
        press(4'h1); press(4'h2); press(4'hB);
        tests++;
        if (err_cnt !== e0 + 1 || nums !== p4(3, 5, 0, 2) || valid_mask !== 4'b1111) begin
            $display("FAIL rej_sub errs=%0d nums=%h mask=%b want %0d", err_cnt, nums, valid_mask, e0 + 1);
            fails++;
        end
        press(4'h1); press(4'h3); press(4'hD);
        tests++;
        if (err_cnt !== e0 + 2 || valid_mask !== 4'b1111) begin
            $display("FAIL rej_div0 errs=%0d mask=%b want %0d 1111", err_cnt, valid_mask, e0 + 2);
            fails++;
        end
        press(4'h1); press(4'h4); press(4'hD);
        tests++;
        if (err_cnt !== e0 + 3 || nums !== p4(3, 5, 0, 2)) begin
            $display("FAIL rej_rem errs=%0d nums=%h want %0d", err_cnt, nums, e0 + 3);
            fails++;
        end
        press(4'h2); press(4'h1); press(4'hB);
        tests++;
        if (nums !== p4(2, 5, 0, 2) || valid_mask !== 4'b1101 || err_cnt !== e0 + 3) begin
            $display("FAIL sub_order nums=%h mask=%b want %h 1101", nums, valid_mask, p4(2, 5, 0, 2));
            fails++;
        end
    endtask

    task automatic test_overflow();
        int e0;
        do_start(p4(1000, 100, 40, 2));
        e0 = err_cnt;
        press(4'h1); press(4'h2); press(4'hA);
        press(4'h1); press(4'h4); press(4'hC);
        press(4'h1); press(4'h3); press(4'hA);
        tests++;
        if (err_cnt !== e0 + 3 || nums !== p4(1000, 100, 40, 2)) begin
            $display("FAIL ovf_reject errs=%0d nums=%h want %0d", err_cnt, nums, e0 + 3);
            fails++;
        end
        press(4'h2); press(4'h4); press(4'hC);
        tests++;
        if (nums !== p4(1000, 200, 40, 2) || valid_mask !== 4'b0111) begin
            $display("FAIL ovf_ok nums=%h mask=%b want %h 0111", nums, valid_mask, p4(1000, 200, 40, 2));
            fails++;
        end
    endtask

    task automatic test_lose();
        do_start(p4(8, 8, 8, 8));
        press(4'h1); press(4'h2); press(4'hA);
        press(4'h3); press(4'h4); press(4'hB);
        press(4'h1); press(4'h3); press(4'hA);
        tests++;
        if (nums !== p4(16, 8, 0, 8) || valid_mask !== 4'b0001) begin
            $display("FAIL lose_nums nums=%h mask=%b want %h 0001", nums, valid_mask, p4(16, 8, 0, 8));
            fails++;
        end
        tests++;
        if (lose !== 1'b1 || win !== 1'b0) begin
            $display("FAIL lose_flags win=%b lose=%b want 0 1", win, lose);
            fails++;
        end
        press(4'h1); press(4'hF); press(4'h1); press(4'hA);
        tests++;
        if (lose !== 1'b1 || nums !== p4(16, 8, 0, 8) || valid_mask !== 4'b0001) begin
            $display("FAIL done_ignore lose=%b nums=%h mask=%b", lose, nums, valid_mask);
            fails++;
        end
    endtask

    task automatic test_restart_reset();
        do_start(p4(2, 3, 4, 5));
        press(4'h1); press(4'h2); press(4'hA);
        tests++;
        if (nums !== p4(5, 3, 4, 5) || valid_mask !== 4'b1101) begin
            $display("FAIL rs_move nums=%h mask=%b want %h 1101", nums, valid_mask, p4(5, 3, 4, 5));
            fails++;
        end
        press(4'h1);
        seed_nums = p4(9, 9, 9, 9);
        do_restart();
        tests++;
        if (nums !== p4(2, 3, 4, 5) || valid_mask !== 4'b1111) begin
            $display("FAIL rs_reload nums=%h mask=%b want %h 1111", nums, valid_mask, p4(2, 3, 4, 5));
            fails++;
        end
        press(4'h3); press(4'h4); press(4'hA);
        tests++;
        if (nums !== p4(2, 3, 9, 5) || valid_mask !== 4'b0111) begin
            $display("FAIL rs_selclr nums=%h mask=%b want %h 0111", nums, valid_mask, p4(2, 3, 9, 5));
            fails++;
        end
        press(4'h1); press(4'h2);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'hA;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
        rst_n     = 1'b0;
        #1;
        tests++;
        if (nums !== '0 || valid_mask !== '0 || {win, lose, err} !== 3'b000) begin
            $display("FAIL exec_reset nums=%h mask=%b flags=%b want 0", nums, valid_mask, {win, lose, err});
            fails++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_restart();
        tests++;
        if (nums !== '0 || valid_mask !== 4'b1111) begin
            $display("FAIL reset_seed nums=%h mask=%b want 0 1111", nums, valid_mask);
            fails++;
        end
    endtask

    task automatic test_same_cycle();
        int e0;
        @(negedge clk);
        seed_nums = p4(4, 6, 1, 1);
        start     = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'h1;
        @(negedge clk);
        start     = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        @(negedge clk);
        press(4'h2); press(4'h3); press(4'hA);
        tests++;
        if (nums !== p4(4, 7, 1, 1) || valid_mask !== 4'b1011) begin
            $display("FAIL key_drop nums=%h mask=%b want %h 1011", nums, valid_mask, p4(4, 7, 1, 1));
            fails++;
        end
        do_start(p4(4, 6, 1, 1));
        e0 = err_cnt;
        press(4'h3); press(4'h3); press(4'h4); press(4'hA);
        tests++;
        if (nums !== p4(4, 6, 2, 1) || valid_mask !== 4'b0111 || err_cnt !== e0) begin
            $display("FAIL same_slot nums=%h mask=%b errs=%0d want %h 0111 %0d",
                     nums, valid_mask, err_cnt, p4(4, 6, 2, 1), e0);
            fails++;
        end
        press(4'h4); press(4'h1); press(4'h2); press(4'hA);
        tests++;
        if (nums !== p4(10, 6, 2, 1) || valid_mask !== 4'b0101 || err_cnt !== e0) begin
            $display("FAIL dead_slot nums=%h mask=%b want %h 0101", nums, valid_mask, p4(10, 6, 2, 1));
            fails++;
        end
        press(4'h3); press(4'h1); press(4'hB);
        tests++;
        if (err_cnt !== e0 + 1 || valid_mask !== 4'b0101) begin
            $display("FAIL sub_neg errs=%0d mask=%b want %0d 0101", err_cnt, valid_mask, e0 + 1);
            fails++;
        end
        press(4'h1); press(4'hA); press(4'hF);
        press(4'h3); press(4'h1); press(4'hC);
        tests++;
        if (nums[W-1:0] !== W'(20) || valid_mask !== 4'b0001 || lose !== 1'b1) begin
            $display("FAIL clr_key n0=%0d mask=%b lose=%b want 20 0001 1", nums[W-1:0], valid_mask, lose);
            fails++;
        end
    endtask

`ifdef UNDO_EN
    task automatic test_undo();
        int e0;
        do_start(p4(4, 6, 1, 1));
        e0 = err_cnt;
        press(4'h1); press(4'h2); press(4'hC);
        press(4'h3); press(4'h4); press(4'hC);
        press(4'hE);
        tests++;
        if (nums !== p4(24, 6, 1, 1) || valid_mask !== 4'b1101) begin
            $display("FAIL undo1 nums=%h mask=%b want %h 1101", nums, valid_mask, p4(24, 6, 1, 1));
            fails++;
        end
        press(4'hE);
        tests++;
        if (nums !== p4(4, 6, 1, 1) || valid_mask !== 4'b1111 || err_cnt !== e0) begin
            $display("FAIL undo2 nums=%h mask=%b want %h 1111", nums, valid_mask, p4(4, 6, 1, 1));
            fails++;
        end
        press(4'hE);
        tests++;
        if (err_cnt !== e0 + 1 || valid_mask !== 4'b1111) begin
            $display("FAIL undo_empty errs=%0d want %0d", err_cnt, e0 + 1);
            fails++;
        end
        press(4'h1); press(4'h2); press(4'hC);
        press(4'h3); press(4'h4); press(4'hC);
        press(4'h1); press(4'h3); press(4'hC);
        press(4'hE);
        tests++;
        if (win !== 1'b0 || valid_mask !== 4'b0101) begin
            $display("FAIL undo_win win=%b mask=%b want 0 0101", win, valid_mask);
            fails++;
        end
        press(4'h1); press(4'h3); press(4'hC);
        tests++;
        if (win !== 1'b1 || valid_mask !== 4'b0001) begin
            $display("FAIL undo_resume win=%b mask=%b want 1 0001", win, valid_mask);
            fails++;
        end
    endtask
`else
    task automatic test_undo_off();
        int e0;
        do_start(p4(4, 6, 1, 1));
        e0 = err_cnt;
        press(4'h1); press(4'h2); press(4'hC);
        press(4'hE);
        tests++;
        if (nums !== p4(24, 6, 1, 1) || valid_mask !== 4'b1101 || err_cnt !== e0) begin
            $display("FAIL undo_off nums=%h mask=%b errs=%0d want %h 1101 %0d",
                     nums, valid_mask, err_cnt, p4(24, 6, 1, 1), e0);
            fails++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_win();
        test_reject();
        test_overflow();
        test_lose();
        test_restart_reset();
        test_same_cycle();
`ifdef UNDO_EN
        test_undo();
`else
        test_undo_off();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
